// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide constants plus the packed commit-trace record.
// Optional COMMIT_TRACE_TIMESTAMP_EN adds a 32-bit capture timestamp to each record.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int NB_REGS    = 5;
    localparam int TRACE_TS_W = 32;

    typedef struct packed {
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        logic [TRACE_TS_W-1:0] timestamp;
`endif
        logic [XLEN-1:0]    pc;
        logic               rd_v;
        logic [NB_REGS-1:0] rd_adr;
        logic [XLEN-1:0]    rd_data;
        logic               csr_v;
        logic [11:0]        csr_adr;
        logic [XLEN-1:0]    csr_data;
        logic               branch_v;
        logic               mem_v;
        logic [XLEN-1:0]    mem_adr;
        logic               store_v;
        logic [XLEN-1:0]    store_data;
    } trace_rec_t;

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// trace_fifo: show-ahead synchronous FIFO with wrap-bit pointers.
// A push while full is taken only when a pop happens in the same cycle.
module trace_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    assign empty_o  = wr_ptr_q == rd_ptr_q;
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o  = wr_ptr_q - rd_ptr_q;
    assign do_pop   = pop_i & ~empty_o;
    assign do_push  = push_i & (~full_o | do_pop);
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    assign data_o   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: packs per-cycle retirement events into trace records, buffers them, counts overflow drops.
// Define COMMIT_TRACE_TIMESTAMP_EN to stamp each record with a free-running cycle counter.
module commit_trace_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wbk_v_i,
    input  logic [NB_REGS-1:0]       wbk_adr_i,
    input  logic [XLEN-1:0]          wbk_data_i,
    input  logic                     wbk_csr_v_i,
    input  logic [11:0]              wbk_csr_adr_i,
    input  logic [XLEN-1:0]          wbk_csr_data_i,
    input  logic                     branch_v_i,
    input  logic                     val_adr_v_i,
    input  logic [XLEN-1:0]          val_adr_i,
    input  logic                     val_store_v_i,
    input  logic [XLEN-1:0]          val_store_data_i,
    input  logic [XLEN-1:0]          pc_val_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output trace_rec_t               trace_rec_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DROP_W-1:0]        drop_cnt_o,
    output logic                     overflow_o,
    input  logic                     clear_i
);
    trace_rec_t        rec;
    logic              evt, pop, full, empty, drop;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [TRACE_TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end
`endif

    assign evt  = wbk_v_i | wbk_csr_v_i | branch_v_i | val_adr_v_i;
    assign pop  = trace_valid_o & trace_ready_i;
    assign drop = evt & full & ~pop;

    always_comb begin
        rec            = '0;
        rec.pc         = pc_val_i;
        rec.rd_v       = wbk_v_i;
        rec.rd_adr     = wbk_v_i ? wbk_adr_i : '0;
        rec.rd_data    = wbk_v_i ? wbk_data_i : '0;
        rec.csr_v      = wbk_csr_v_i;
        rec.csr_adr    = wbk_csr_v_i ? wbk_csr_adr_i : '0;
        rec.csr_data   = wbk_csr_v_i ? wbk_csr_data_i : '0;
        rec.branch_v   = branch_v_i;
        rec.mem_v      = val_adr_v_i;
        rec.mem_adr    = val_adr_v_i ? val_adr_i : '0;
        rec.store_v    = val_store_v_i;
        rec.store_data = val_store_v_i ? val_store_data_i : '0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        rec.timestamp  = ts_q;
`endif
    end

    // Clear wins over history but not over a drop in the same cycle.
    always_comb begin
        drop_cnt_d = clear_i ? '0 : drop_cnt_q;
        if (drop && !(&drop_cnt_d)) drop_cnt_d = drop_cnt_d + 1'b1;
        overflow_d = (overflow_q & ~clear_i) | drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .DATA_W ($bits(trace_rec_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (evt),
        .pop_i   (pop),
        .data_i  (rec),
        .data_o  (trace_rec_o),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    assign trace_valid_o = ~empty;
    assign drop_cnt_o    = drop_cnt_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: scoreboard bench; a reference queue is filled at capture and compared against the head record.
// Timestamp checks are built only when COMMIT_TRACE_TIMESTAMP_EN is defined.
module tb_commit_trace_buffer;
    import riscv_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic               wbk_v_i = 1'b0;
    logic [NB_REGS-1:0] wbk_adr_i = '0;
    logic [XLEN-1:0]    wbk_data_i = '0;
    logic               wbk_csr_v_i = 1'b0;
    logic [11:0]        wbk_csr_adr_i = '0;
    logic [XLEN-1:0]    wbk_csr_data_i = '0;
    logic               branch_v_i = 1'b0;
    logic               val_adr_v_i = 1'b0;
    logic [XLEN-1:0]    val_adr_i = '0;
    logic               val_store_v_i = 1'b0;
    logic [XLEN-1:0]    val_store_data_i = '0;
    logic [XLEN-1:0]    pc_val_i = '0;
    logic               trace_ready_i = 1'b0;
    logic               clear_i = 1'b0;
    logic               trace_valid_o;
    trace_rec_t         trace_rec_o;
    logic [CW-1:0]      count_o;
    logic [DROP_W-1:0]  drop_cnt_o;
    logic               overflow_o;

    commit_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wbk_v_i          (wbk_v_i),
        .wbk_adr_i        (wbk_adr_i),
        .wbk_data_i       (wbk_data_i),
        .wbk_csr_v_i      (wbk_csr_v_i),
        .wbk_csr_adr_i    (wbk_csr_adr_i),
        .wbk_csr_data_i   (wbk_csr_data_i),
        .branch_v_i       (branch_v_i),
        .val_adr_v_i      (val_adr_v_i),
        .val_adr_i        (val_adr_i),
        .val_store_v_i    (val_store_v_i),
        .val_store_data_i (val_store_data_i),
        .pc_val_i         (pc_val_i),
        .trace_valid_o    (trace_valid_o),
        .trace_ready_i    (trace_ready_i),
        .trace_rec_o      (trace_rec_o),
        .count_o          (count_o),
        .drop_cnt_o       (drop_cnt_o),
        .overflow_o       (overflow_o),
        .clear_i          (clear_i)
    );

    trace_rec_t        exp_q[$];
    logic [DROP_W-1:0] drop_m = '0;
    logic              ovf_m = 1'b0;
    logic [31:0]       ts_m = '0;
    int                n_chk = 0;
    int                n_fail = 0;
    bit                chk_en = 1'b0;
    bit                m_pop, m_evt, m_drop;
    int                m_sz;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic trace_rec_t exp_rec();
        trace_rec_t r;
        r = '0;
        r.pc       = pc_val_i;
        r.rd_v     = wbk_v_i;
        r.csr_v    = wbk_csr_v_i;
        r.branch_v = branch_v_i;
        r.mem_v    = val_adr_v_i;
        r.store_v  = val_store_v_i;
        if (wbk_v_i) begin
            r.rd_adr  = wbk_adr_i;
            r.rd_data = wbk_data_i;
        end
        if (wbk_csr_v_i) begin
            r.csr_adr  = wbk_csr_adr_i;
            r.csr_data = wbk_csr_data_i;
        end
        if (val_adr_v_i) r.mem_adr = val_adr_i;
        if (val_store_v_i) r.store_data = val_store_data_i;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        r.timestamp = ts_m;
`endif
        return r;
    endfunction

    // Reference model: queue occupancy, drops and the cycle counter advance on each edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            drop_m = '0;
            ovf_m  = 1'b0;
            ts_m   = '0;
        end else begin
            m_sz   = exp_q.size();
            m_pop  = trace_ready_i && m_sz > 0;
            m_evt  = wbk_v_i | wbk_csr_v_i | branch_v_i | val_adr_v_i;
            m_drop = m_evt && m_sz == DEPTH && !m_pop;
            if (m_evt && !m_drop) exp_q.push_back(exp_rec());
            if (m_pop) void'(exp_q.pop_front());
            if (clear_i) drop_m = '0;
            if (m_drop && drop_m != '1) drop_m = drop_m + 1'b1;
            ovf_m = (ovf_m & ~clear_i) | m_drop;
            ts_m  = ts_m + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 256'(count_o), 256'(exp_q.size()));
            chk("valid", 256'(trace_valid_o), 256'(exp_q.size() > 0));
            chk("drop_cnt", 256'(drop_cnt_o), 256'(drop_m));
            chk("overflow", 256'(overflow_o), 256'(ovf_m));
            if (exp_q.size() > 0) chk("head_rec", 256'(trace_rec_o), 256'(exp_q[0]));
        end
    end

    task automatic drive(input logic [3:0] v);
        wbk_v_i          = v[0];
        wbk_csr_v_i      = v[1];
        branch_v_i       = v[2];
        val_adr_v_i      = v[3];
        wbk_adr_i        = NB_REGS'($urandom);
        wbk_data_i       = $urandom;
        wbk_csr_adr_i    = 12'($urandom);
        wbk_csr_data_i   = $urandom;
        val_adr_i        = $urandom;
        val_store_v_i    = 1'($urandom_range(0, 1));
        val_store_data_i = $urandom;
        pc_val_i         = $urandom;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain();
        trace_ready_i = 1'b1;
        drive(4'd0);
        for (int i = 0; i < 3 * DEPTH && exp_q.size() > 0; i++) tick();
        chk("drained", 256'(exp_q.size()), 256'(0));
        trace_ready_i = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_count", 256'(count_o), 256'(0));
        chk("rst_valid", 256'(trace_valid_o), 256'(0));
        chk("rst_drop", 256'(drop_cnt_o), 256'(0));
        chk("rst_ovf", 256'(overflow_o), 256'(0));
        reset_n = 1'b1;
        chk_en  = 1'b1;
        drive(4'd0);
        wbk_v_i    = 1'b1;
        wbk_adr_i  = 5'd5;
        wbk_data_i = 32'hDEAD_BEEF;
        pc_val_i   = 32'h8000_0000;
        val_store_v_i = 1'b0;
        tick();
        drive(4'd0);
        chk("rd_valid", 256'(trace_valid_o), 256'(1));
        chk("rd_v", 256'(trace_rec_o.rd_v), 256'(1));
        chk("rd_adr", 256'(trace_rec_o.rd_adr), 256'(5));
        chk("rd_data", 256'(trace_rec_o.rd_data), 256'(32'hDEAD_BEEF));
        chk("rd_pc", 256'(trace_rec_o.pc), 256'(32'h8000_0000));
        chk("rd_count", 256'(count_o), 256'(1));
        drain();
        for (int i = 0; i < 10; i++) tick();
        chk("idle_count", 256'(count_o), 256'(0));
        chk("idle_valid", 256'(trace_valid_o), 256'(0));
        for (int i = 0; i < 20; i++) begin
            drive(4'($urandom_range(1, 15)));
            tick();
        end
        drive(4'd0);
        tick();
        chk("ovf_count", 256'(count_o), 256'(16));
        chk("ovf_drop", 256'(drop_cnt_o), 256'(4));
        chk("ovf_flag", 256'(overflow_o), 256'(1));
        trace_ready_i = 1'b1;
        drive(4'b0101);
        tick();
        trace_ready_i = 1'b0;
        drive(4'd0);
        chk("full_pp_count", 256'(count_o), 256'(16));
        chk("full_pp_drop", 256'(drop_cnt_o), 256'(4));
        drive(4'b1000);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        drive(4'd0);
        chk("clr_drop", 256'(drop_cnt_o), 256'(1));
        chk("clr_ovf", 256'(overflow_o), 256'(1));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_only_drop", 256'(drop_cnt_o), 256'(0));
        chk("clr_only_ovf", 256'(overflow_o), 256'(0));
        drain();
        for (int i = 0; i < 80; i++) begin
            drive($urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(1, 15)));
            trace_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        trace_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0011);
            tick();
        end
        drive(4'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", 256'(count_o), 256'(0));
        chk("async_rst_valid", 256'(trace_valid_o), 256'(0));
        tick();
        reset_n = 1'b1;
        tick();
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive((c == 3 || c == 7) ? 4'b0100 : 4'd0);
            tick();
        end
        drive(4'd0);
        chk("ts3", 256'(trace_rec_o.timestamp), 256'(3));
        trace_ready_i = 1'b1;
        tick();
        trace_ready_i = 1'b0;
        chk("ts7", 256'(trace_rec_o.timestamp), 256'(7));
        drain();
        force dut.ts_q = 32'hFFFF_FFFF;
        ts_m = 32'hFFFF_FFFF;
        #1 release dut.ts_q;
        tick();
        drive(4'b0001);
        tick();
        drive(4'd0);
        chk("ts_wrap", 256'(trace_rec_o.timestamp), 256'(0));
        drain();
`endif
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
